// File: rtl/udma_i2s_rx_arbiter.sv
// udma_i2s_rx_arbiter: shares one uDMA RX channel between NUM_CHANNELS
// sample streams. It grants by round-robin or strict alternation. It can
// pack two 16-bit samples into one word. The output word is registered
// with one cycle of latency. It counts the cycles the output is stalled
// by backpressure.

// Per-channel qualification: a channel takes part only when it is enabled.
// The ready output is forced low for masked channels.
module udma_i2s_rx_arbiter_lane (
    input  logic mask,
    input  logic valid,
    input  logic grant,
    output logic eligible,
    output logic ready
);

    assign eligible = mask & valid;
    assign ready    = grant & mask;

endmodule

module udma_i2s_rx_arbiter #(
    parameter int NUM_CHANNELS = 2,
    parameter int DATA_WIDTH   = 32,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                                      clk_i,
    input  logic                                      rst_i,
    input  logic                                      cfg_en_i,
    input  logic [NUM_CHANNELS-1:0]                   cfg_ch_mask_i,
    input  logic                                      cfg_strict_i,
    input  logic                                      cfg_pack16_i,
    input  logic                                      cfg_clr_i,
    input  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]   ch_data_i,
    input  logic [NUM_CHANNELS-1:0]                   ch_valid_i,
    output logic [NUM_CHANNELS-1:0]                   ch_ready_o,
    output logic [DATA_WIDTH-1:0]                     out_data_o,
    output logic                                      out_valid_o,
    input  logic                                      out_ready_i,
    output logic [((NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1)-1:0] out_ch_id_o,
    output logic [CNT_WIDTH-1:0]                      stall_cnt_o
);

    localparam int IDW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [IDW-1:0]          ptr_q;
    logic [15:0]             hold_q;

    logic [NUM_CHANNELS-1:0] eligible;
    logic [NUM_CHANNELS-1:0] grant;
    logic [IDW-1:0]          grant_idx;
    logic                    found;
    logic                    slot_free;
    logic                    can_grant;
    logic                    accept;
    logic [DATA_WIDTH-1:0]   sample;
    logic [DATA_WIDTH-1:0]   pack_word;
    logic                    load_full;
    logic                    load_half;
    logic                    load_pack;

    // The output register is the only buffer, so a new sample can be taken
    // only when the current word is absent or leaves this cycle. The reset
    // term keeps ready low while reset is held, even though the grant
    // logic is combinational.
    assign out_valid_o = (state_q == FULL);
    assign slot_free   = !out_valid_o || out_ready_i;
    assign can_grant   = cfg_en_i && slot_free && !cfg_clr_i && !rst_i;
    assign accept      = |grant;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_lane
            udma_i2s_rx_arbiter_lane u_lane (
                .mask     (cfg_ch_mask_i[gi]),
                .valid    (ch_valid_i[gi]),
                .grant    (grant[gi]),
                .eligible (eligible[gi]),
                .ready    (ch_ready_o[gi])
            );
        end
    endgenerate

    // Channel search starts one past the last grant.
    // Round-robin takes the first eligible channel.
    // Strict mode stops at the first enabled channel. If that channel is
    // not valid, nothing is granted this cycle.
    always_comb begin
        int             cand;
        logic [IDW-1:0] cidx;
        logic           searching;
        cand      = 0;
        cidx      = '0;
        searching = 1'b1;
        found     = 1'b0;
        grant_idx = '0;
        grant     = '0;
        for (int k = 1; k <= NUM_CHANNELS; k++) begin
            cand = (int'(ptr_q) + k) % NUM_CHANNELS;
            cidx = IDW'(cand);
            if (searching && cfg_ch_mask_i[cidx]) begin
                if (eligible[cidx]) begin
                    grant_idx = cidx;
                    found     = 1'b1;
                    searching = 1'b0;
                end else if (cfg_strict_i) begin
                    searching = 1'b0;
                end
            end
        end
        if (found && can_grant) begin
            grant[grant_idx] = 1'b1;
        end
    end

    // Select the granted sample, and form the packed word from the held
    // low half plus the new low half.
    always_comb begin
        sample          = ch_data_i[grant_idx];
        pack_word       = '0;
        pack_word[31:0] = {sample[15:0], hold_q};
    end

    // Output-register state flop.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and load strobes.
    // The pack setting is sampled only when a new word starts.
    // A word that is half built always completes as a packed word.
    always_comb begin
        state_d   = state_q;
        load_full = 1'b0;
        load_half = 1'b0;
        load_pack = 1'b0;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    if (cfg_pack16_i) begin
                        state_d   = HALF;
                        load_half = 1'b1;
                    end else begin
                        state_d   = FULL;
                        load_full = 1'b1;
                    end
                end
            end
            HALF: begin
                if (accept) begin
                    state_d   = FULL;
                    load_pack = 1'b1;
                end
            end
            FULL: begin
                if (out_ready_i) begin
                    if (accept) begin
                        if (cfg_pack16_i) begin
                            state_d   = HALF;
                            load_half = 1'b1;
                        end else begin
                            state_d   = FULL;
                            load_full = 1'b1;
                        end
                    end else begin
                        state_d = EMPTY;
                    end
                end
            end
            default: state_d = EMPTY;
        endcase
        if (cfg_clr_i) begin
            state_d   = EMPTY;
            load_full = 1'b0;
            load_half = 1'b0;
            load_pack = 1'b0;
        end
    end

    // Output word, channel id and half-word holding register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_data_o  <= '0;
            out_ch_id_o <= '0;
            hold_q      <= '0;
        end else begin
            if (load_full) begin
                out_data_o  <= sample;
                out_ch_id_o <= grant_idx;
            end
            if (load_pack) begin
                out_data_o  <= pack_word;
                out_ch_id_o <= grant_idx;
            end
            if (load_half) begin
                hold_q <= sample[15:0];
            end
            if (cfg_clr_i) begin
                hold_q <= '0;
            end
        end
    end

    // Arbitration pointer: it holds the last granted channel. Clear
    // returns it to the last channel, so the next search starts at ch0.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= IDW'(NUM_CHANNELS - 1);
        end else if (cfg_clr_i) begin
            ptr_q <= IDW'(NUM_CHANNELS - 1);
        end else if (accept) begin
            ptr_q <= grant_idx;
        end
    end

    // Saturating count of cycles where a presented word is refused.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_o <= '0;
        end else if (cfg_clr_i) begin
            stall_cnt_o <= '0;
        end else if (out_valid_o && !out_ready_i && !(&stall_cnt_o)) begin
            stall_cnt_o <= stall_cnt_o + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_udma_i2s_rx_arbiter.sv
// Scoreboard bench for udma_i2s_rx_arbiter. Stimulus pushes the expected
// words into a queue. A monitor pops and compares each word the DUT hands
// over.
`timescale 1ns/1ps
module tb_udma_i2s_rx_arbiter;

    localparam int N  = 2;
    localparam int DW = 32;
    localparam int CW = 16;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 cfg_en = 1'b1;
    logic [N-1:0]         cfg_mask = 2'b11;
    logic                 cfg_strict = 1'b0;
    logic                 cfg_pack = 1'b0;
    logic                 cfg_clr = 1'b0;
    logic [N-1:0][DW-1:0] ch_data = '0;
    logic [N-1:0]         ch_valid = '0;
    logic [N-1:0]         ch_ready;
    logic [DW-1:0]        out_data;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic                 out_id;
    logic [CW-1:0]        stall_cnt;

    typedef struct {
        logic [31:0] d;
        logic        id;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    udma_i2s_rx_arbiter #(.NUM_CHANNELS(N), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .cfg_en_i      (cfg_en),
        .cfg_ch_mask_i (cfg_mask),
        .cfg_strict_i  (cfg_strict),
        .cfg_pack16_i  (cfg_pack),
        .cfg_clr_i     (cfg_clr),
        .ch_data_i     (ch_data),
        .ch_valid_i    (ch_valid),
        .ch_ready_o    (ch_ready),
        .out_data_o    (out_data),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .out_ch_id_o   (out_id),
        .stall_cnt_o   (stall_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [31:0] d, input logic id);
        exp_t e;
        e.d  = d;
        e.id = id;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_pulse();
        cfg_clr = 1'b1;
        tick();
        cfg_clr = 1'b0;
    endtask

    // Both channels stream base+count, advancing only on their own handshake.
    task automatic run_src(input int n, input logic [31:0] b0, input logic [31:0] b1,
                           output int cyc);
        int         c0;
        int         c1;
        logic [1:0] fire;
        c0 = 0;
        c1 = 0;
        cyc = 0;
        ch_data[0] = b0;
        ch_data[1] = b1;
        ch_valid = 2'b11;
        while ((c0 + c1) < n && cyc < 50) begin
            @(negedge clk);
            fire = ch_valid & ch_ready;
            tick();
            cyc++;
            if (fire[0]) c0++;
            if (fire[1]) c1++;
            ch_data[0] = b0 + 32'(c0);
            ch_data[1] = b1 + 32'(c1);
        end
        ch_valid = '0;
        chk("src_accepts", 64'(c0 + c1), 64'(n));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired act=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        fork
            begin
                exp_t e;
                forever begin
                    @(negedge clk);
                    if (!rst && out_valid && out_ready) begin
                        if (q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL mon_unexpected act=%0h exp=none", out_data);
                        end else begin
                            e = q.pop_front();
                            chk("mon_data", 64'(out_data), 64'(e.d));
                            chk("mon_id", 64'(out_id), 64'(e.id));
                        end
                    end
                end
            end
        join_none

        // Reset state; ready must stay low even with valid requests.
        ch_valid = 2'b11;
        #12;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_stall", 64'(stall_cnt), 64'd0);
        chk("rst_ready", 64'(ch_ready), 64'd0);
        ch_valid = '0;
        tick();
        rst = 1'b0;
        tick();

        // 1: round-robin, both streaming, one word per cycle.
        for (int k = 0; k < 4; k++) begin
            push(32'hA0 + 32'(k), 1'b0);
            push(32'hB0 + 32'(k), 1'b1);
        end
        run_src(8, 32'hA0, 32'hB0, cyc);
        chk("t1_cycles", 64'(cyc), 64'd8);
        tick();
        clr_pulse();

        // 2: strict alternation waits for ch0 even though ch1 is valid.
        cfg_strict = 1'b1;
        ch_data[0] = 32'hC0;
        ch_data[1] = 32'hC1;
        ch_valid = 2'b10;
        push(32'hC0, 1'b0);
        push(32'hC1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t2_wait_ready", 64'(ch_ready), 64'd0);
            tick();
        end
        ch_valid = 2'b11;
        @(negedge clk);
        chk("t2_ready_ch0", 64'(ch_ready), 64'b01);
        tick();
        ch_valid = 2'b10;
        @(negedge clk);
        chk("t2_ready_ch1", 64'(ch_ready), 64'b10);
        tick();
        ch_valid = '0;
        cfg_strict = 1'b0;
        clr_pulse();

        // 3: pack16 builds a word from two grants.
        cfg_pack = 1'b1;
        ch_data[0] = 32'h1111AAAA;
        ch_data[1] = 32'h2222BBBB;
        ch_valid = 2'b11;
        push(32'hBBBBAAAA, 1'b1);
        @(negedge clk);
        chk("t3_ready0", 64'(ch_ready), 64'b01);
        tick();
        @(negedge clk);
        chk("t3_half_valid", 64'(out_valid), 64'd0);
        chk("t3_ready1", 64'(ch_ready), 64'b10);
        tick();
        ch_valid = '0;
        @(negedge clk);
        chk("t3_full_valid", 64'(out_valid), 64'd1);
        tick();
        cfg_pack = 1'b0;
        clr_pulse();

        // 4: backpressure for 10 cycles.
        out_ready = 1'b0;
        ch_data[0] = 32'hD0;
        ch_valid = 2'b01;
        push(32'hD0, 1'b0);
        push(32'hD1, 1'b0);
        @(negedge clk);
        chk("t4_ready", 64'(ch_ready), 64'b01);
        tick();
        ch_data[0] = 32'hD1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t4_stall_ready", 64'(ch_ready), 64'd0);
            chk("t4_stable", 64'(out_data), 64'hD0);
            @(posedge clk);
        end
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("t4_stall_cnt", 64'(stall_cnt), 64'd10);
        chk("t4_release_ready", 64'(ch_ready), 64'b01);
        tick();
        ch_valid = '0;
        tick();

        // 5: mask ch1; clear while a half word is held.
        cfg_mask = 2'b01;
        cfg_pack = 1'b1;
        ch_data[0] = 32'h00001234;
        ch_data[1] = 32'h99999999;
        ch_valid = 2'b11;
        @(negedge clk);
        chk("t5_ready_mask", 64'(ch_ready), 64'b01);
        chk("t5_stall_kept", 64'(stall_cnt), 64'd10);
        tick();
        ch_valid = '0;
        cfg_clr = 1'b1;
        @(negedge clk);
        chk("t5_half_valid", 64'(out_valid), 64'd0);
        tick();
        cfg_clr = 1'b0;
        @(negedge clk);
        chk("t5_clr_valid", 64'(out_valid), 64'd0);
        chk("t5_clr_stall", 64'(stall_cnt), 64'd0);
        tick();
        ch_data[0] = 32'h55550001;
        ch_valid = 2'b11;
        push(32'h00030001, 1'b0);
        @(negedge clk);
        chk("t5_ready_a", 64'(ch_ready), 64'b01);
        tick();
        ch_data[0] = 32'h55550003;
        @(negedge clk);
        chk("t5_ready_b", 64'(ch_ready), 64'b01);
        tick();
        ch_valid = '0;
        @(negedge clk);
        chk("t5_word_valid", 64'(out_valid), 64'd1);
        tick();
        cfg_mask = 2'b11;
        cfg_pack = 1'b0;

        // 6: reset while FULL and stalled, then round-robin restarts at ch0.
        out_ready = 1'b0;
        ch_data[0] = 32'h60;
        ch_data[1] = 32'h61;
        ch_valid = 2'b11;
        @(negedge clk);
        chk("t6_ready_ch1", 64'(ch_ready), 64'b10);
        tick();
        ch_valid = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("t6_pre_stall", 64'(stall_cnt), 64'd3);
        chk("t6_pre_valid", 64'(out_valid), 64'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", 64'(out_valid), 64'd0);
        chk("t6_rst_data", 64'(out_data), 64'd0);
        chk("t6_rst_id", 64'(out_id), 64'd0);
        chk("t6_rst_stall", 64'(stall_cnt), 64'd0);
        chk("t6_rst_ready", 64'(ch_ready), 64'd0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        push(32'h70, 1'b0);
        push(32'h80, 1'b1);
        run_src(2, 32'h70, 32'h80, cyc);
        tick();
        tick();
        chk("sb_drained", 64'(q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
